// File: rtl/div_ctrl_pkg.sv
// +----------------------------------------------------------------------------+
// | div_ctrl_pkg : shared state encodings and helpers for the divide sequencer |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

package div_ctrl_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // Index of the last restoring step; one quotient bit is produced per step.
  function automatic int div_last_step(input int width);
    return width - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// +----------------------------------------------------------------------------+
// | div_step : one combinational radix-2 restoring division step               |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] r_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] r_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH:0] r_sh;
  logic [WIDTH:0] trial;
  logic           ge;

  // The shifted remainder needs one extra bit: divisors reach 2^WIDTH-1.
  assign r_sh  = {r_in, q_in[WIDTH-1]};
  assign ge    = (r_sh >= {1'b0, divisor});
  assign trial = r_sh - {1'b0, divisor};
  assign r_out = ge ? WIDTH'(trial) : WIDTH'(r_sh);
  assign q_out = {q_in[WIDTH-2:0], ge};

endmodule

`default_nettype wire

// File: rtl/div_ctrl.sv
// +----------------------------------------------------------------------------+
// | div_ctrl : multi-cycle DIV/DIVU sequencer with pipeline stall and annul    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             annul,
  output logic             stall_o,
  output logic             valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(div_last_step(WIDTH));

  div_state_t       state, next_state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_p, quo_p, dvsr;
  logic             q_neg, r_neg;
  logic [WIDTH-1:0] step_r, step_q;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic             accept, b_zero, last_step;

  // 0x80000000 negates to itself, which is exactly the unsigned magnitude.
  assign a_abs     = (signed_div && a[WIDTH-1]) ? -a : a;
  assign b_abs     = (signed_div && b[WIDTH-1]) ? -b : b;
  assign b_zero    = (b == '0);
  assign last_step = (cnt == LAST);

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_in    (rem_p),
    .q_in    (quo_p),
    .divisor (dvsr),
    .r_out   (step_r),
    .q_out   (step_q)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= DIV_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    stall_o    = 1'b0;
    accept     = 1'b0;
    case (state)
      DIV_IDLE: begin
        if (start && !annul) begin
          accept     = 1'b1;
          stall_o    = 1'b1;
          next_state = b_zero ? DIV_DONE : DIV_RUN;
        end
      end
      DIV_RUN: begin
        stall_o = 1'b1;
        if (annul)          next_state = DIV_IDLE;
        else if (last_step) next_state = DIV_DONE;
      end
      DIV_DONE: next_state = DIV_IDLE;
      default:  next_state = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      cnt       <= '0;
      rem_p     <= '0;
      quo_p     <= '0;
      dvsr      <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
    end else begin
      valid <= (next_state == DIV_DONE);
      if (accept) begin
        if (b_zero) begin
          quotient  <= '1;
          remainder <= a;
        end else begin
          quo_p <= a_abs;
          dvsr  <= b_abs;
          rem_p <= '0;
          cnt   <= '0;
          q_neg <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
          r_neg <= signed_div & a[WIDTH-1];
        end
      end else if (state == DIV_RUN && !annul) begin
        rem_p <= step_r;
        quo_p <= step_q;
        cnt   <= cnt + 1'b1;
        if (last_step) begin
          quotient  <= q_neg ? -step_q : step_q;
          remainder <= r_neg ? -step_r : step_r;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_div_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_div_ctrl : self-checking bench for div_ctrl against an arithmetic model |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, signed_div, annul;
  logic [31:0] a, b;
  logic        stall_o, valid;
  logic [31:0] quotient, remainder;
  int          checks = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  div_ctrl #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .a          (a),
    .b          (b),
    .annul      (annul),
    .stall_o    (stall_o),
    .valid      (valid),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  // MIPS semantics: truncating division, remainder takes the dividend's sign.
  function automatic void model(input logic [31:0] ta, tb, input logic tsd,
                                output logic [31:0] eq, er, output int lat);
    longint sa, sb;
    if (tb == 32'd0) begin
      eq = 32'hFFFF_FFFF; er = ta; lat = 1;
    end else if (tsd) begin
      sa = longint'($signed(ta)); sb = longint'($signed(tb));
      eq = 32'(sa / sb); er = 32'(sa % sb); lat = 33;
    end else begin
      eq = ta / tb; er = ta % tb; lat = 33;
    end
  endfunction

  // Holds start until valid; reports results, valid cycle and stall/idle errors.
  task automatic run_op(input logic [31:0] ta, tb, input logic tsd, input bit scramble,
                        output logic [31:0] gq, gr, output int vcyc, stall_err, idle_err);
    @(posedge clk); #1;
    a = ta; b = tb; signed_div = tsd; start = 1'b1;
    vcyc = -1; stall_err = 0; gq = '0; gr = '0;
    for (int c = 0; c < 100 && vcyc < 0; c++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        vcyc = c; gq = quotient; gr = remainder;
        if (stall_o !== 1'b0) stall_err++;
      end else if (stall_o !== 1'b1) stall_err++;
      @(posedge clk); #1;
      if (scramble && c == 3) begin
        a = $urandom; b = $urandom; signed_div = ~signed_div;
      end
    end
    start = 1'b0;
    @(negedge clk);
    idle_err = ((valid !== 1'b0) || (stall_o !== 1'b0)) ? 1 : 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if ({stall_o, valid} !== 2'b00) $display("FAIL reset_ctrl: got %b expected 00", {stall_o, valid}); else passed++;
    checks++; if ({quotient, remainder} !== 64'd0) $display("FAIL reset_data: got %h expected 0", {quotient, remainder}); else passed++;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_unsigned();
    logic [31:0] gq, gr; int v, se, ie;
    run_op(32'd100, 32'd7, 1'b0, 1'b0, gq, gr, v, se, ie);
    checks++; if (gq !== 32'd14) $display("FAIL divu_quotient: got %h expected %h", gq, 32'd14); else passed++;
    checks++; if (gr !== 32'd2) $display("FAIL divu_remainder: got %h expected %h", gr, 32'd2); else passed++;
    checks++; if (v !== 33) $display("FAIL divu_valid_cycle: got %0d expected 33", v); else passed++;
    checks++; if (se !== 0) $display("FAIL divu_stall: got %0d bad cycles expected 0", se); else passed++;
    checks++; if (ie !== 0) $display("FAIL divu_idle_after: got %0d expected 0", ie); else passed++;
  endtask

  task automatic test_signed();
    logic [31:0] gq, gr; int v, se, ie;
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, gq, gr, v, se, ie);
    checks++; if ({gq, gr} !== {32'hFFFF_FFFD, 32'hFFFF_FFFF}) $display("FAIL div_neg7_by_2: got %h expected fffffffdffffffff", {gq, gr}); else passed++;
    run_op(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, gq, gr, v, se, ie);
    checks++; if ({gq, gr} !== {32'h7FFF_FFFC, 32'd1}) $display("FAIL divu_fff9_by_2: got %h expected 7ffffffc00000001", {gq, gr}); else passed++;
  endtask

  task automatic test_div_zero();
    logic [31:0] gq, gr; int v, se, ie;
    run_op(32'd5, 32'd0, 1'b1, 1'b0, gq, gr, v, se, ie);
    checks++; if ({gq, gr} !== {32'hFFFF_FFFF, 32'd5}) $display("FAIL divzero_result: got %h expected ffffffff00000005", {gq, gr}); else passed++;
    checks++; if (v !== 1) $display("FAIL divzero_valid_cycle: got %0d expected 1", v); else passed++;
    checks++; if (se !== 0 || ie !== 0) $display("FAIL divzero_stall: got %0d/%0d expected 0/0", se, ie); else passed++;
  endtask

  task automatic test_overflow();
    logic [31:0] gq, gr; int v, se, ie;
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, gq, gr, v, se, ie);
    checks++; if ({gq, gr} !== {32'h8000_0000, 32'd0}) $display("FAIL overflow_result: got %h expected 8000000000000000", {gq, gr}); else passed++;
    checks++; if (v !== 33) $display("FAIL overflow_valid_cycle: got %0d expected 33", v); else passed++;
  endtask

  task automatic test_annul();
    logic [31:0] gq, gr; int v, se, ie; bit seen; int vc;
    run_op(32'd100, 32'd7, 1'b0, 1'b0, gq, gr, v, se, ie);
    @(posedge clk); #1;
    a = 32'd1000; b = 32'd3; signed_div = 1'b0; start = 1'b1; seen = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      if (c == 10) annul = 1'b1;
      @(negedge clk);
      if (valid !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    annul = 1'b0; start = 1'b0; #1;
    checks++; if (seen || valid !== 1'b0) $display("FAIL annul_no_valid: got %b expected 0", seen | valid); else passed++;
    checks++; if (stall_o !== 1'b0) $display("FAIL annul_stall_drop: got %b expected 0", stall_o); else passed++;
    checks++; if ({quotient, remainder} !== {32'd14, 32'd2}) $display("FAIL annul_keeps_result: got %h expected 0000000e00000002", {quotient, remainder}); else passed++;
    a = 32'd9; b = 32'd3; start = 1'b1; vc = -1;
    for (int c = 11; c < 120 && vc < 0; c++) begin
      @(negedge clk);
      if (valid === 1'b1) begin vc = c; gq = quotient; gr = remainder; end
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++; if (vc !== 44) $display("FAIL annul_restart_cycle: got %0d expected 44", vc); else passed++;
    checks++; if ({gq, gr} !== {32'd3, 32'd0}) $display("FAIL annul_restart_result: got %h expected 0000000300000000", {gq, gr}); else passed++;
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] gq, gr, eq, er; int v, se, ie, lat; bit seen;
    @(posedge clk); #1;
    a = 32'd50000; b = 32'd7; signed_div = 1'b0; start = 1'b1; seen = 1'b0;
    for (int c = 0; c <= 20; c++) begin
      if (c == 20) begin rst = 1'b1; start = 1'b0; end
      @(negedge clk);
      if (valid !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++; if (seen || {stall_o, valid} !== 2'b00) $display("FAIL rst_mid_ctrl: got %b%b%b expected 000", seen, stall_o, valid); else passed++;
    checks++; if ({quotient, remainder} !== 64'd0) $display("FAIL rst_mid_data: got %h expected 0", {quotient, remainder}); else passed++;
    @(posedge clk); #1 rst = 1'b0;
    run_op(32'd123456789, 32'd1234, 1'b0, 1'b1, gq, gr, v, se, ie);
    model(32'd123456789, 32'd1234, 1'b0, eq, er, lat);
    checks++; if ({gq, gr} !== {eq, er}) $display("FAIL operand_change_u: got %h expected %h", {gq, gr}, {eq, er}); else passed++;
    run_op(32'hF000_0001, 32'd77, 1'b1, 1'b1, gq, gr, v, se, ie);
    model(32'hF000_0001, 32'd77, 1'b1, eq, er, lat);
    checks++; if ({gq, gr} !== {eq, er}) $display("FAIL operand_change_s: got %h expected %h", {gq, gr}, {eq, er}); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] q1, r1, q2, r2, e1q, e1r, e2q, e2r; int v1, v2, l1, l2; logic s34;
    model(32'd1000, 32'd10, 1'b0, e1q, e1r, l1);
    model(32'hFFFF_FC18, 32'd7, 1'b1, e2q, e2r, l2);
    @(posedge clk); #1;
    a = 32'd1000; b = 32'd10; signed_div = 1'b0; start = 1'b1;
    v1 = -1; v2 = -1; s34 = 1'bx; q1 = '0; r1 = '0; q2 = '0; r2 = '0;
    for (int c = 0; c < 120 && v2 < 0; c++) begin
      @(negedge clk);
      if (c == 34) s34 = stall_o;
      if (valid === 1'b1) begin
        if (v1 < 0) begin v1 = c; q1 = quotient; r1 = remainder; end
        else begin v2 = c; q2 = quotient; r2 = remainder; end
      end
      @(posedge clk); #1;
      if (v1 == c) begin a = 32'hFFFF_FC18; b = 32'd7; signed_div = 1'b1; end
    end
    start = 1'b0;
    checks++; if ({q1, r1} !== {e1q, e1r}) $display("FAIL b2b_first: got %h expected %h", {q1, r1}, {e1q, e1r}); else passed++;
    checks++; if ({q2, r2} !== {e2q, e2r}) $display("FAIL b2b_second: got %h expected %h", {q2, r2}, {e2q, e2r}); else passed++;
    checks++; if (v1 !== l1 || v2 !== l1 + 1 + l2) $display("FAIL b2b_timing: got %0d,%0d expected %0d,%0d", v1, v2, l1, l1 + 1 + l2); else passed++;
    checks++; if (s34 !== 1'b1) $display("FAIL b2b_issue_stall: got %b expected 1", s34); else passed++;
  endtask

  task automatic test_random();
    logic [31:0] ta, tb, gq, gr, eq, er; logic tsd; int v, se, ie, lat;
    for (int i = 0; i < 24; i++) begin
      ta  = $urandom;
      tsd = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       tb = $urandom;
        1:       tb = 32'($urandom_range(1, 255));
        2:       tb = -32'($urandom_range(1, 16));
        default: tb = (i % 6 == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
      endcase
      model(ta, tb, tsd, eq, er, lat);
      run_op(ta, tb, tsd, i[0], gq, gr, v, se, ie);
      checks++; if (gq !== eq) $display("FAIL rand%0d_quotient: got %h expected %h (a=%h b=%h s=%b)", i, gq, eq, ta, tb, tsd); else passed++;
      checks++; if (gr !== er) $display("FAIL rand%0d_remainder: got %h expected %h (a=%h b=%h s=%b)", i, gr, er, ta, tb, tsd); else passed++;
      checks++; if (v !== lat) $display("FAIL rand%0d_valid_cycle: got %0d expected %0d", i, v, lat); else passed++;
      checks++; if (se !== 0 || ie !== 0) $display("FAIL rand%0d_stall: got %0d/%0d expected 0/0", i, se, ie); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_annul();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
